// File: rtl/chroma_upsample_sequencer.sv
// Sequencer for the U/V 6-tap chroma interpolation FIR. Walks the packed U and V
// planes line by line, issues SRAM read addresses and drives the datapath
// strobes. One U'/V' pair per 6-cycle slot; every output is registered.
module chroma_upsample_sequencer #(
  parameter logic [17:0] U_BASE         = 18'd38400,
  parameter logic [17:0] V_BASE         = 18'd57600,
  parameter int unsigned WORDS_PER_LINE = 80,
  parameter int unsigned LINES          = 240
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
  input  logic        stall,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic        line_start,
  output logic        line_end,
  output logic        common_case,
  output logic        enable_U,
  output logic        enable_V,
  output logic        load_U_buffer,
  output logic        load_V_buffer,
  output logic        read_U_0,
  output logic        read_V_0,
  output logic        cycle,
  output logic        pair_valid,
  output logic [7:0]  line_index,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WW = $clog2(WORDS_PER_LINE + 1);
  localparam int unsigned SW = $clog2(2 * WORDS_PER_LINE);
  localparam logic [SW-1:0] LAST_COMMON = SW'(2 * WORDS_PER_LINE - 5);
  localparam logic [SW-1:0] LAST_TAIL   = SW'(3);
  localparam logic [7:0]    LAST_LINE   = 8'(LINES - 1);
  localparam logic [17:0]   LINE_STEP   = 18'(WORDS_PER_LINE);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_COMMON, S_TAIL, S_DONE} state_t;

  state_t        r_state, w_state;
  logic [2:0]    r_phase, w_phase;
  logic [WW-1:0] r_word, w_word;
  logic [SW-1:0] r_slot, w_slot;
  logic          r_cycle, w_cycle;
  logic [7:0]    r_line, w_line;
  logic [17:0]   r_off, w_off;
  logic          w_hold;

  logic [17:0] r_addr, w_addr;
  logic r_ls, r_le, r_cc, r_en_u, r_en_v, r_ld_u, r_ld_v, r_rd_u0, r_rd_v0;
  logic r_cyc_q, r_pv, r_busy, r_done;
  logic [7:0] r_line_q;
  logic w_ls, w_le, w_cc, w_en_u, w_en_v, w_ld_u, w_ld_v, w_rd_u0, w_rd_v0;
  logic w_pv, w_busy, w_done;

  // Sequencer state: FSM, phase/word/slot counters, line position
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_word  <= '0;
      r_slot  <= '0;
      r_cycle <= 1'b0;
      r_line  <= '0;
      r_off   <= '0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_word  <= w_word;
      r_slot  <= w_slot;
      r_cycle <= w_cycle;
      r_line  <= w_line;
      r_off   <= w_off;
    end
  end

  // Next-state and per-cycle strobe decode; a stalled boundary cycle freezes everything
  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_word  = r_word;
    w_slot  = r_slot;
    w_cycle = r_cycle;
    w_line  = r_line;
    w_off   = r_off;
    w_addr  = r_addr;
    w_ls = 1'b0; w_le = 1'b0; w_cc = 1'b0;
    w_en_u = 1'b0; w_en_v = 1'b0; w_ld_u = 1'b0; w_ld_v = 1'b0;
    w_rd_u0 = 1'b0; w_rd_v0 = 1'b0; w_pv = 1'b0;
    w_busy = 1'b0; w_done = 1'b0;
    w_hold = stall && (r_phase == 3'd0) &&
             (r_state == S_LEAD || r_state == S_COMMON || r_state == S_TAIL);
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_LEAD;
          w_phase = '0;
          w_word  = '0;
          w_slot  = '0;
          w_cycle = 1'b0;
          w_line  = '0;
          w_off   = '0;
        end
      end
      S_LEAD: begin
        w_busy = 1'b1;
        w_ls   = 1'b1;
        if (!w_hold) begin
          w_phase = r_phase + 3'd1;
          case (r_phase)
            3'd0: w_addr = U_BASE + r_off;
            3'd1: w_addr = V_BASE + r_off;
            3'd2: begin w_addr = U_BASE + r_off + 18'd1; w_rd_u0 = 1'b1; end
            3'd3: begin w_addr = V_BASE + r_off + 18'd1; w_rd_v0 = 1'b1; end
            3'd4: w_en_u = 1'b1;
            default: begin
              w_en_v  = 1'b1;
              w_state = S_COMMON;
              w_phase = '0;
              w_word  = WW'(2);
              w_slot  = '0;
              w_cycle = 1'b0;
            end
          endcase
        end
      end
      S_COMMON: begin
        w_busy = 1'b1;
        w_cc   = 1'b1;
        if (!w_hold) begin
          w_phase = r_phase + 3'd1;
          case (r_phase)
            3'd0: if (!r_cycle) w_addr = U_BASE + r_off + 18'(r_word);
            3'd1: begin
              if (!r_cycle) begin
                w_addr = V_BASE + r_off + 18'(r_word);
                w_word = r_word + WW'(1);
              end
            end
            3'd2: begin w_en_u = 1'b1; w_ld_u = !r_cycle; end
            3'd3: begin w_en_v = 1'b1; w_ld_v = !r_cycle; end
            3'd4: ;
            default: begin
              w_pv    = 1'b1;
              w_cycle = !r_cycle;
              w_phase = '0;
              if (r_slot == LAST_COMMON) begin
                w_state = S_TAIL;
                w_slot  = '0;
              end else begin
                w_slot = r_slot + SW'(1);
              end
            end
          endcase
        end
      end
      S_TAIL: begin
        w_busy = 1'b1;
        w_le   = 1'b1;
        if (!w_hold) begin
          w_phase = r_phase + 3'd1;
          case (r_phase)
            3'd2: w_en_u = 1'b1;
            3'd3: w_en_v = 1'b1;
            3'd5: begin
              w_pv    = 1'b1;
              w_phase = '0;
              if (r_slot == LAST_TAIL) begin
                w_slot = '0;
                if (r_line == LAST_LINE) begin
                  w_state = S_DONE;
                end else begin
                  w_line  = r_line + 8'd1;
                  w_off   = r_off + LINE_STEP;
                  w_state = S_LEAD;
                end
              end else begin
                w_slot = r_slot + SW'(1);
              end
            end
            default: ;
          endcase
        end
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Output register stage: every port is driven from a flop
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_addr <= '0;
      r_ls <= 1'b0; r_le <= 1'b0; r_cc <= 1'b0;
      r_en_u <= 1'b0; r_en_v <= 1'b0; r_ld_u <= 1'b0; r_ld_v <= 1'b0;
      r_rd_u0 <= 1'b0; r_rd_v0 <= 1'b0;
      r_cyc_q <= 1'b0; r_pv <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
      r_line_q <= '0;
    end else begin
      r_addr <= w_addr;
      r_ls <= w_ls; r_le <= w_le; r_cc <= w_cc;
      r_en_u <= w_en_u; r_en_v <= w_en_v; r_ld_u <= w_ld_u; r_ld_v <= w_ld_v;
      r_rd_u0 <= w_rd_u0; r_rd_v0 <= w_rd_v0;
      r_cyc_q <= r_cycle; r_pv <= w_pv; r_busy <= w_busy; r_done <= w_done;
      r_line_q <= r_line;
    end
  end

  assign SRAM_address  = r_addr;
  assign SRAM_we_n     = 1'b1;
  assign line_start    = r_ls;
  assign line_end      = r_le;
  assign common_case   = r_cc;
  assign enable_U      = r_en_u;
  assign enable_V      = r_en_v;
  assign load_U_buffer = r_ld_u;
  assign load_V_buffer = r_ld_v;
  assign read_U_0      = r_rd_u0;
  assign read_V_0      = r_rd_v0;
  assign cycle         = r_cyc_q;
  assign pair_valid    = r_pv;
  assign line_index    = r_line_q;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_chroma_upsample_sequencer.sv
// Bench for chroma_upsample_sequencer with a 4-word, 2-line frame.
module tb_chroma_upsample_sequencer;
  localparam int W  = 4;
  localparam int L  = 2;
  localparam int UB = 100;
  localparam int VB = 200;

  logic clk = 1'b0;
  logic resetn = 1'b0, start = 1'b0, stall = 1'b0;
  logic [17:0] SRAM_address;
  logic SRAM_we_n, line_start, line_end, common_case, enable_U, enable_V;
  logic load_U_buffer, load_V_buffer, read_U_0, read_V_0, cycle, pair_valid;
  logic [7:0] line_index;
  logic busy, done;

  chroma_upsample_sequencer #(
    .U_BASE(18'(UB)), .V_BASE(18'(VB)), .WORDS_PER_LINE(W), .LINES(L)
  ) dut (
    .CLOCK_50_I(clk), .resetn(resetn), .start(start), .stall(stall),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n),
    .line_start(line_start), .line_end(line_end), .common_case(common_case),
    .enable_U(enable_U), .enable_V(enable_V),
    .load_U_buffer(load_U_buffer), .load_V_buffer(load_V_buffer),
    .read_U_0(read_U_0), .read_V_0(read_V_0), .cycle(cycle),
    .pair_valid(pair_valid), .line_index(line_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard and monitor statistics
  int exp_q[$];
  int c_pv, c_pv_com, c_pv_tail, c_enu, c_env, c_ldu, c_ldv, c_rdu, c_rdv, c_done;
  int t_busy, t_done;
  int t_ls[$];
  logic exp_cyc = 1'b0;
  logic [17:0] prev_addr = '0;
  logic prev_busy = 1'b0, prev_ls = 1'b0;

  always @(negedge clk) begin
    if (busy && SRAM_address != prev_addr) begin
      if (exp_q.size() == 0) check("addr_extra", SRAM_address, -1);
      else check("addr", SRAM_address, exp_q.pop_front());
    end
    prev_addr = SRAM_address;
    if (busy && !prev_busy) t_busy = cyc;
    prev_busy = busy;
    if (line_start && !prev_ls) begin
      t_ls.push_back(cyc);
      exp_cyc = 1'b0;
    end
    prev_ls = line_start;
    if (pair_valid) c_pv++;
    if (pair_valid && line_end) c_pv_tail++;
    if (pair_valid && common_case) begin
      c_pv_com++;
      check("cycle_alt", cycle, exp_cyc);
      exp_cyc = ~exp_cyc;
    end
    if (enable_U) c_enu++;
    if (enable_V) c_env++;
    if (load_U_buffer) begin c_ldu++; check("ldU_when_cycle0", cycle, 0); end
    if (load_V_buffer) begin c_ldv++; check("ldV_when_cycle0", cycle, 0); end
    if (read_U_0) c_rdu++;
    if (read_V_0) c_rdv++;
    if (done) begin c_done++; t_done = cyc; end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_stats();
    c_pv = 0; c_pv_com = 0; c_pv_tail = 0; c_enu = 0; c_env = 0;
    c_ldu = 0; c_ldv = 0; c_rdu = 0; c_rdv = 0; c_done = 0;
    t_busy = 0; t_done = 0;
    t_ls.delete();
  endtask

  task automatic push_frame();
    for (int l = 0; l < L; l++)
      for (int w = 0; w < W; w++) begin
        exp_q.push_back(UB + l * W + w);
        exp_q.push_back(VB + l * W + w);
      end
  endtask

  function automatic longint out_vec();
    return {SRAM_address, SRAM_we_n, line_start, line_end, common_case, enable_U,
            enable_V, load_U_buffer, load_V_buffer, read_U_0, read_V_0, cycle,
            pair_valid, line_index, busy, done};
  endfunction

  // reset image: only SRAM_we_n (bit 21) is high
  localparam longint RST_VEC = longint'(1) << 21;

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (c_done == 0 && n < bound) begin tick(); n++; end
    check("done_seen", c_done, 1);
    check("line_index_at_done", line_index, L - 1);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_frame(input int exp_len, input int exp_line0);
    check("frame_len", t_done - t_busy, exp_len);
    check("line_starts", t_ls.size(), L);
    if (t_ls.size() == L) check("line0_len", t_ls[1] - t_ls[0], exp_line0);
    check("pv_count", c_pv, L * 2 * W);
    check("pv_common", c_pv_com, L * (2 * W - 4));
    check("pv_tail", c_pv_tail, L * 4);
    check("enU_count", c_enu, L * (2 * W + 1));
    check("enV_count", c_env, L * (2 * W + 1));
    check("ldU_count", c_ldu, L * (W - 2));
    check("ldV_count", c_ldv, L * (W - 2));
    check("rdU0_count", c_rdu, L);
    check("rdV0_count", c_rdv, L);
    check("addr_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic any_strobe;
    // reset state
    #1;
    check("reset_outputs", out_vec(), RST_VEC);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (5) tick();
    check("idle_busy", busy, 0);
    check("idle_addr", SRAM_address, 0);

    // frame 1: plain run, address sequence and latencies
    @(posedge clk);
    clr_stats();
    push_frame();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_lat_early", busy, 0);
    tick();
    check("busy_lat", busy, 1);
    check("first_addr", SRAM_address, UB);
    wait_done(400);
    check_frame(108, 54);

    // frame 2: stall at p0 of slot 3, stall at p2 of slot 5, start while busy
    repeat (3) tick();
    @(posedge clk);
    clr_stats();
    push_frame();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (c_pv < 3 && n < 200) begin tick(); n++; end
    check("reach_slot3", c_pv, 3);
    stall = 1'b1;
    any_strobe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_strobe |= enable_U | enable_V | load_U_buffer | load_V_buffer |
                    read_U_0 | read_V_0 | pair_valid;
    end
    stall = 1'b0;
    check("strobes_in_hold", any_strobe, 0);
    n = 0;
    while (c_pv < 5 && n < 200) begin tick(); n++; end
    tick();
    tick();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    n = 0;
    while (t_ls.size() < 2 && n < 200) begin tick(); n++; end
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("start_ignored_line", line_index, 1);
    check("start_ignored_busy", busy, 1);
    wait_done(400);
    check_frame(118, 64);
    repeat (20) tick();
    check("single_done", c_done, 1);

    // frame 3: reset in the middle of the common phase
    @(posedge clk);
    clr_stats();
    push_frame();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("in_common", common_case, 1);
    resetn = 1'b0;
    #1;
    check("midline_reset", out_vec(), RST_VEC);
    exp_q.delete();
    repeat (3) tick();
    resetn = 1'b1;
    repeat (10) tick();
    check("post_reset_idle", out_vec(), RST_VEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/chroma_upsample_sequencer.md
# chroma_upsample_sequencer

Sequencer for the U/V 6-tap interpolation FIR datapath in the colour-space conversion stage. It walks the down-sampled U and V planes in SRAM line by line and issues the read addresses. It drives the datapath control strobes: `line_start`, `line_end`, `common_case`, `enable_U/V`, `load_U/V_buffer`, `read_U_0/V_0` and `cycle`. One U' and one V' value are produced per 6-cycle slot.

## Interface

Parameters:
- `U_BASE`, 18'd38400: SRAM word address of U plane, line 0 word 0.
- `V_BASE`, 18'd57600: SRAM word address of V plane.
- `WORDS_PER_LINE`, 80: packed words per chroma line (2 samples/word, high byte first); must be ≥ 3.
- `LINES`, 240: lines per frame.

Ports:
- `CLOCK_50_I`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  1-cycle pulse; begins a frame when idle.
- `stall`  in  1  downstream not ready; sampled only at slot/line boundaries.
- `SRAM_address`  out  18  read word address.
- `SRAM_we_n`  out  1  constant 1 (read-only).
- `line_start`, `line_end`, `common_case`  out  1 each  datapath phase flags.
- `enable_U`, `enable_V`, `load_U_buffer`, `load_V_buffer`, `read_U_0`, `read_V_0`  out  1 each  datapath strobes.
- `cycle`  out  1  0: shift high byte of fresh word; 1: shift buffered low byte.
- `pair_valid`  out  1  pulse at last cycle of every output slot.
- `line_index`  out  8  current line.
- `busy`  out  1  high from cycle after accepted `start` until `done`.
- `done`  out  1  1-cycle pulse after final slot of line `LINES-1`.

## Operation

- SRAM read data is valid two cycles after the address is presented. Address = plane base + `line_index`*`WORDS_PER_LINE` + word index `w`.
- States: `S_IDLE`, `S_LEAD` (c0..c5), `S_COMMON` (slot phases p0..p5), `S_TAIL` (p0..p5), `S_DONE`.
- `S_IDLE`: all strobes 0. `start`=1 → `S_LEAD`, `line_index`=0, `busy`=1. `start` is ignored when not idle.
- `S_LEAD` (`line_start`=1 throughout):
  - c0 issues U w0; c1 issues V w0.
  - c2 issues U w1 with `read_U_0`=1.
  - c3 issues V w1 with `read_V_0`=1.
  - c4 `enable_U`=1; c5 `enable_V`=1.
  - Then `S_COMMON`, w=2, `cycle`=0.
- `S_COMMON` (`common_case`=1), 2*`WORDS_PER_LINE`-4 slots:
  - If `cycle`=0: p0 issues U w, p1 issues V w, and w increments after p1.
  - p2: `enable_U`=1, with `load_U_buffer`=1 iff `cycle`=0.
  - p3: `enable_V`=1, with `load_V_buffer`=1 iff `cycle`=0.
  - p5: `pair_valid`=1, then `cycle` toggles.
  - After the last slot → `S_TAIL`.
- `S_TAIL` (`line_end`=1), exactly 4 slots, no SRAM reads:
  - p2 `enable_U`=1; p3 `enable_V`=1; p5 `pair_valid`=1.
  - After the 4th slot: if `line_index`=`LINES-1` → `S_DONE`; else increment `line_index` → `S_LEAD`.
- `S_DONE`: `done`=1 for one cycle, `busy`=0, → `S_IDLE`.
- Stall: `stall`=1 at `S_LEAD` c0 or at any slot's p0 holds that cycle. While held, all strobes and `pair_valid` are 0 and the address is unchanged. `stall` is ignored at every other phase, since reads are in flight.
- Slots per line = 2*`WORDS_PER_LINE`; exactly `WORDS_PER_LINE` reads per plane per line.
- Reset (any time, including mid-line) → `S_IDLE`.
  - All outputs 0 except `SRAM_we_n`=1.
  - `SRAM_address`=0, `cycle`=0, `line_index`=0, word/slot counters 0.

## Timing

- `start` sampled at edge N → `busy`=1 and `SRAM_address`=`U_BASE` after edge N+1 (`S_LEAD` c0).
- Unstalled line = 12*`WORDS_PER_LINE`+6 cycles (966 at default). Frame = `LINES` × that, plus 1 `S_DONE` cycle.
- All outputs are registered. Strobes are high for exactly one cycle per phase listed; no other strobe is high in any other cycle.
- `pair_valid` count per line = 2*`WORDS_PER_LINE`.

## Test plan

- Reset check: assert `resetn`=0 mid-`S_COMMON` → every output returns to its reset value within the reset cycle; after release it stays idle until `start`.
- Address sequence check: `WORDS_PER_LINE`=4, `LINES`=2, `U_BASE`=100, `V_BASE`=200, pulse `start` → addresses 100,200,101,201,102,202,103,203 on line 0, then 104,204,… on line 1. `done` pulses 108 cycles after `busy` rises.
- Cycle/load check: in `S_COMMON`, `load_U_buffer` is high only in slots with `cycle`=0, and `cycle` alternates 0,1,0,1; 4 `S_COMMON` slots then 4 `S_TAIL` slots with `line_end`=1.
- Stall check: hold `stall`=1 for 10 cycles at p0 of slot 3 → line length grows by exactly 10 cycles, with no strobes during the hold. `stall` at p2 has no effect.
- Busy/start check: pulse `start` again while `busy` → ignored (exactly one `done` pulse, `line_index` not reset). A second `start` after `done` begins a new frame at `U_BASE`.
- Count check: run the full default frame → 240×160 `pair_valid` pulses, 240×80 U reads and 240×80 V reads, frame length 231841 cycles.
